// File: rtl/regfile_operand_fetch.sv
// Operand fetch unit: issues reads to the register file for decoded instructions,
// tracks pending destinations in a scoreboard and hands operands to execute via valid/ready.
module regfile_operand_fetch #(
    parameter int RD_LATENCY = 1,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [4:0]        dec_rs1,
    input  logic [4:0]        dec_rs2,
    input  logic [4:0]        dec_rd,
    input  logic              dec_rd_we,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [4:0]        rf_readaddr1,
    output logic [4:0]        rf_readaddr2,
    output logic [4:0]        rf_writeaddr,
    output logic [DATA_W-1:0] rf_writedata,
    output logic              rf_RegWrite,
    input  logic [DATA_W-1:0] rf_readdata1,
    input  logic [DATA_W-1:0] rf_readdata2,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [4:0]        op_rd,
    output logic              op_rd_we
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam int              CNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LATENCY - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      busy;
    logic [31:0]      busy_next;
    logic             stall;
    logic             dispatch;

    // The write port is a straight pass-through; writeback is never stalled.
    assign rf_RegWrite  = wb_valid;
    assign rf_writeaddr = wb_rd;
    assign rf_writedata = wb_data;

    assign dec_ready = (state == IDLE);
    assign dispatch  = op_valid && op_ready;

    // A write in the sampling cycle would race the read, so writeback also holds off issue.
    assign stall = wb_valid
                || ((rf_readaddr1 != 5'd0) && busy[rf_readaddr1])
                || ((rf_readaddr2 != 5'd0) && busy[rf_readaddr2]);

    always_comb begin
        busy_next = busy;
        if (wb_valid) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (dispatch && op_rd_we && (op_rd != 5'd0)) begin
            busy_next[op_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Read addresses double as the latched source fields for the instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            rf_readaddr1 <= 5'd0;
            rf_readaddr2 <= 5'd0;
            op_rd        <= 5'd0;
            op_rd_we     <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            op_valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dec_valid) begin
                        rf_readaddr1 <= dec_rs1;
                        rf_readaddr2 <= dec_rs2;
                        op_rd        <= dec_rd;
                        op_rd_we     <= dec_rd_we;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        op_a     <= (rf_readaddr1 == 5'd0) ? '0 : rf_readdata1;
                        op_b     <= (rf_readaddr2 == 5'd0) ? '0 : rf_readdata2;
                        op_valid <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
